// File: rtl/axis_frame_status_sink.sv
// AXI-Stream frame sink: counts bytes per frame from tkeep, classifies the
// frame on its last beat and presents one status record per frame through a
// valid/ready handshake, plus wrapping frame and bad-frame counters.
module axis_frame_status_sink #(
  parameter int                    DATA_WIDTH           = 64,
  parameter int                    KEEP_ENABLE          = (DATA_WIDTH > 8),
  parameter int                    KEEP_WIDTH           = (DATA_WIDTH / 8),
  parameter int                    USER_WIDTH           = 1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = USER_WIDTH'(1'b1),
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK  = USER_WIDTH'(1'b1),
  parameter int                    LEN_WIDTH            = 16,
  parameter int                    MAX_LEN              = 1518
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic                  m_status_valid,
  input  logic                  m_status_ready,
  output logic [LEN_WIDTH-1:0]  m_status_len,
  output logic                  m_status_bad,
  output logic                  m_status_oversize,
  output logic                  m_status_saturated,
  output logic [31:0]           frame_count,
  output logic [31:0]           bad_frame_count
);

  localparam int CNT_W = $clog2(KEEP_WIDTH + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t               state;
  logic [LEN_WIDTH-1:0] acc;
  logic                 sticky_sat;

  logic                 beat_ok;
  logic [CNT_W-1:0]     beat_bytes;
  logic [LEN_WIDTH:0]   sum;
  logic                 sat_now;
  logic [LEN_WIDTH-1:0] len_next;
  logic                 bad_next;

  // Payload is never inspected; tkeep is ignored when keep is disabled.
  logic unused_inputs;
  assign unused_inputs = ^{s_axis_tdata, s_axis_tkeep};

  function automatic logic [CNT_W-1:0] popcount(input logic [KEEP_WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < KEEP_WIDTH; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  assign s_axis_tready = !(m_status_valid && !m_status_ready);
  assign beat_ok       = s_axis_tvalid && s_axis_tready;

  // Per-beat byte count and saturating running length including this beat.
  always_comb begin
    beat_bytes = (KEEP_ENABLE != 0) ? popcount(s_axis_tkeep) : CNT_W'(KEEP_WIDTH);
    sum        = {1'b0, acc} + (LEN_WIDTH + 1)'(beat_bytes);
    sat_now    = sum[LEN_WIDTH];
    len_next   = sat_now ? '1 : sum[LEN_WIDTH-1:0];
    bad_next   = ((s_axis_tuser & USER_BAD_FRAME_MASK) ==
                  (USER_BAD_FRAME_VALUE & USER_BAD_FRAME_MASK));
  end

  // Frame FSM, accumulator and registered status record.
  // Record acceptance drops valid first; a last-beat load on the same edge
  // overrides that, giving one record per cycle at full throughput.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      acc                <= '0;
      sticky_sat         <= 1'b0;
      m_status_valid     <= 1'b0;
      m_status_len       <= '0;
      m_status_bad       <= 1'b0;
      m_status_oversize  <= 1'b0;
      m_status_saturated <= 1'b0;
      frame_count        <= '0;
      bad_frame_count    <= '0;
    end else begin
      if (m_status_valid && m_status_ready) m_status_valid <= 1'b0;
      if (beat_ok) begin
        if (s_axis_tlast) begin
          state              <= IDLE;
          acc                <= '0;
          sticky_sat         <= 1'b0;
          m_status_valid     <= 1'b1;
          m_status_len       <= len_next;
          m_status_bad       <= bad_next;
          m_status_oversize  <= (32'(len_next) > 32'(MAX_LEN));
          m_status_saturated <= sticky_sat | sat_now;
          frame_count        <= frame_count + 32'd1;
          if (bad_next) bad_frame_count <= bad_frame_count + 32'd1;
        end else begin
          state      <= ACTIVE;
          acc        <= len_next;
          sticky_sat <= sticky_sat | sat_now;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_frame_status_sink.sv
// Directed bench for axis_frame_status_sink: default instance plus an
// 8-bit length instance for the saturation case.
module tb_axis_frame_status_sink;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [63:0] tdata = '0;
  logic [7:0]  tkeep = '0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic        tlast = 1'b0;
  logic [0:0]  tuser = '0;
  logic        st_valid;
  logic        st_ready = 1'b1;
  logic [15:0] st_len;
  logic        st_bad, st_over, st_sat;
  logic [31:0] fcnt, bcnt;

  logic [7:0]  s8_tkeep = '0;
  logic        s8_tvalid = 1'b0;
  logic        s8_tready;
  logic        s8_tlast = 1'b0;
  logic [0:0]  s8_tuser = '0;
  logic        s8_valid;
  logic [7:0]  s8_len;
  logic        s8_bad, s8_over, s8_sat;
  logic [31:0] s8_fcnt, s8_bcnt;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  axis_frame_status_sink dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
    .m_status_valid(st_valid), .m_status_ready(st_ready), .m_status_len(st_len),
    .m_status_bad(st_bad), .m_status_oversize(st_over), .m_status_saturated(st_sat),
    .frame_count(fcnt), .bad_frame_count(bcnt)
  );

  axis_frame_status_sink #(.LEN_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(tdata), .s_axis_tkeep(s8_tkeep), .s_axis_tvalid(s8_tvalid),
    .s_axis_tready(s8_tready), .s_axis_tlast(s8_tlast), .s_axis_tuser(s8_tuser),
    .m_status_valid(s8_valid), .m_status_ready(1'b1), .m_status_len(s8_len),
    .m_status_bad(s8_bad), .m_status_oversize(s8_over), .m_status_saturated(s8_sat),
    .frame_count(s8_fcnt), .bad_frame_count(s8_bcnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one beat, wait (bounded) for tready, return 1ns after acceptance.
  task automatic beat(input logic [7:0] k, input logic l, input logic u);
    int unsigned waited;
    waited = 0;
    tkeep = k; tlast = l; tuser = u; tvalid = 1'b1;
    while (!tready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!tready) begin
      n_tests++;
      n_fail++;
      $display("FAIL beat_timeout: observed tready=0 expected 1");
    end
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] kv [5];
    kv[0] = 8'h01; kv[1] = 8'h03; kv[2] = 8'h07; kv[3] = 8'h0F; kv[4] = 8'h1F;

    // Reset values
    #12;
    check("rst_tready", 32'(tready), 32'd1);
    check("rst_valid", 32'(st_valid), 32'd0);
    check("rst_len", 32'(st_len), 32'd0);
    check("rst_fcnt", fcnt, 32'd0);
    check("rst_bcnt", bcnt, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // 3-beat frame FF,FF,0F -> 20 bytes
    beat(8'hFF, 1'b0, 1'b0);
    beat(8'hFF, 1'b0, 1'b0);
    beat(8'h0F, 1'b1, 1'b0);
    check("f1_valid", 32'(st_valid), 32'd1);
    check("f1_len", 32'(st_len), 32'd20);
    check("f1_bad", 32'(st_bad), 32'd0);
    check("f1_over", 32'(st_over), 32'd0);
    check("f1_sat", 32'(st_sat), 32'd0);
    check("f1_fcnt", fcnt, 32'd1);
    idle_cycle();
    check("f1_drop", 32'(st_valid), 32'd0);

    // Single-beat bad frame, FSM stays IDLE
    check("f2_state_pre", 32'(dut.state), 32'd0);
    beat(8'h01, 1'b1, 1'b1);
    check("f2_state_post", 32'(dut.state), 32'd0);
    check("f2_len", 32'(st_len), 32'd1);
    check("f2_bad", 32'(st_bad), 32'd1);
    check("f2_bcnt", bcnt, 32'd1);
    check("f2_fcnt", fcnt, 32'd2);
    idle_cycle();

    // Backpressure: record held, input stalls, no beat lost
    st_ready = 1'b0;
    beat(8'hFF, 1'b1, 1'b0);
    check("bp_len_a", 32'(st_len), 32'd8);
    tkeep = 8'hFF; tlast = 1'b0; tuser = 1'b0; tvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_tready_lo", 32'(tready), 32'd0);
      check("bp_hold_len", 32'(st_len), 32'd8);
      check("bp_hold_valid", 32'(st_valid), 32'd1);
    end
    st_ready = 1'b1; #1;
    check("bp_tready_hi", 32'(tready), 32'd1);
    @(posedge clk); #1;
    tvalid = 1'b0;
    check("bp_drop", 32'(st_valid), 32'd0);
    beat(8'h03, 1'b1, 1'b0);
    check("bp_len_b", 32'(st_len), 32'd10);
    check("bp_fcnt", fcnt, 32'd4);

    // Back-to-back single-beat frames, one record per cycle
    for (int i = 0; i < 5; i++) begin
      check("b2b_tready", 32'(tready), 32'd1);
      beat(kv[i], 1'b1, i[0]);
      check("b2b_valid", 32'(st_valid), 32'd1);
      check("b2b_len", 32'(st_len), 32'(i + 1));
      check("b2b_fcnt", fcnt, 32'(5 + i));
    end
    check("b2b_bcnt", bcnt, 32'd3);
    idle_cycle();

    // Zero-keep last beat
    beat(8'hFF, 1'b0, 1'b0);
    beat(8'h00, 1'b1, 1'b0);
    check("zk_len", 32'(st_len), 32'd8);
    check("zk_fcnt", fcnt, 32'd10);
    beat(8'h00, 1'b1, 1'b0);
    check("zk1_len", 32'(st_len), 32'd0);
    check("zk1_fcnt", fcnt, 32'd11);

    // Oversize boundary: 1518 not oversize, 1520 oversize
    for (int i = 0; i < 189; i++) beat(8'hFF, 1'b0, 1'b0);
    beat(8'h3F, 1'b1, 1'b0);
    check("ov_len_1518", 32'(st_len), 32'd1518);
    check("ov_1518", 32'(st_over), 32'd0);
    for (int i = 0; i < 189; i++) beat(8'hFF, 1'b0, 1'b0);
    beat(8'hFF, 1'b1, 1'b0);
    check("ov_len_1520", 32'(st_len), 32'd1520);
    check("ov_1520", 32'(st_over), 32'd1);
    check("ov_fcnt", fcnt, 32'd13);
    idle_cycle();

    // Reset mid-frame
    beat(8'hFF, 1'b0, 1'b0);
    beat(8'hFF, 1'b0, 1'b0);
    rst_n = 1'b0; #1;
    check("mr_valid", 32'(st_valid), 32'd0);
    check("mr_len", 32'(st_len), 32'd0);
    check("mr_fcnt", fcnt, 32'd0);
    check("mr_bcnt", bcnt, 32'd0);
    check("mr_tready", 32'(tready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    idle_cycle();
    check("mr_no_rec", 32'(st_valid), 32'd0);
    beat(8'h0F, 1'b1, 1'b0);
    check("mr_len_new", 32'(st_len), 32'd4);
    check("mr_fcnt_new", fcnt, 32'd1);

    // Saturation on the 8-bit length instance: 40 x 8 bytes -> 255
    @(negedge clk);
    s8_tkeep = 8'hFF; s8_tvalid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s8_tlast = (i == 39);
      @(posedge clk); #1;
    end
    s8_tvalid = 1'b0; s8_tlast = 1'b0;
    check("sat_valid", 32'(s8_valid), 32'd1);
    check("sat_len", 32'(s8_len), 32'd255);
    check("sat_flag", 32'(s8_sat), 32'd1);
    check("sat_over", 32'(s8_over), 32'd0);
    check("sat_fcnt", s8_fcnt, 32'd1);
    s8_tvalid = 1'b1; s8_tlast = 1'b1;
    @(posedge clk); #1;
    s8_tvalid = 1'b0; s8_tlast = 1'b0;
    check("sat_clr_len", 32'(s8_len), 32'd8);
    check("sat_clr_flag", 32'(s8_sat), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_frame_status_sink.md
AXIS_FRAME_STATUS_SINK -- requirements
Module: axis_frame_status_sink

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: s_axis_tdata width in bits.
REQ-002 SHALL have parameter KEEP_ENABLE, default (DATA_WIDTH>8): use tkeep; when 0, every beat counts KEEP_WIDTH bytes.
REQ-003 SHALL have parameter KEEP_WIDTH, default (DATA_WIDTH/8): tkeep width.
REQ-004 SHALL have parameter USER_WIDTH, default 1: tuser width.
REQ-005 SHALL have parameter USER_BAD_FRAME_VALUE, default 1'b1: tuser value marking a bad frame.
REQ-006 SHALL have parameter USER_BAD_FRAME_MASK, default 1'b1: tuser bits compared.
REQ-007 SHALL have parameter LEN_WIDTH, default 16: frame length counter width in bytes.
REQ-008 SHALL have parameter MAX_LEN, default 1518: oversize threshold in bytes.
REQ-009 SHALL have ports (name direction width meaning):
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- s_axis_tdata  in  DATA_WIDTH  data, ignored.
- s_axis_tkeep  in  KEEP_WIDTH  byte enables.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat accept.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tuser  in  USER_WIDTH  sideband; sampled on the last beat.
- m_status_valid  out  1  status record valid.
- m_status_ready  in  1  status record accept.
- m_status_len  out  LEN_WIDTH  frame byte count.
- m_status_bad  out  1  tuser matched the bad-frame marker.
- m_status_oversize  out  1  length > MAX_LEN.
- m_status_saturated  out  1  length counter saturated.
- frame_count  out  32  frames completed, wraps.
- bad_frame_count  out  32  bad frames completed, wraps.

Function
REQ-010 SHALL accept a beat when s_axis_tvalid && s_axis_tready.
REQ-011 SHALL drive s_axis_tready = !(m_status_valid && !m_status_ready): input stalls only while an unaccepted record is pending; tready SHALL NOT depend on s_axis_tvalid.
REQ-012 SHALL add popcount(s_axis_tkeep) (or KEEP_WIDTH when KEEP_ENABLE=0) per accepted beat; per-beat byte count SHALL be ceil(log2(KEEP_WIDTH+1)) bits.
REQ-013 SHALL saturate the accumulator at 2^LEN_WIDTH-1 and set a sticky saturated flag for that frame.
REQ-014 SHALL use states IDLE (no frame open) and ACTIVE (frame open): IDLE->ACTIVE on an accepted non-last beat; ACTIVE->IDLE on an accepted last beat; a single-beat frame stays in IDLE.
REQ-015 SHALL load the status register on the clock edge that accepts a last beat: len = accumulator + beat bytes (saturating), bad = ((tuser & MASK) == (VALUE & MASK)), oversize = (len > MAX_LEN), saturated = sticky flag or saturation on this beat; m_status_valid rises the next cycle (latency 1).
REQ-016 SHALL clear the accumulator and sticky flag on the same edge, so the next frame's first beat may be accepted in the following cycle.
REQ-017 SHALL hold status outputs stable while m_status_valid && !m_status_ready, and drop m_status_valid after acceptance unless a new record loads on that same edge.
REQ-018 Simultaneous record acceptance and last-beat acceptance SHALL load the new record with m_status_valid remaining 1 (full throughput, one frame per cycle).
REQ-019 SHALL increment frame_count by 1 per loaded record and bad_frame_count by 1 per record with bad=1, both wrapping 2^32-1 -> 0.
REQ-020 A zero-keep last beat SHALL count 0 bytes and still complete the frame.

Reset
REQ-021 On rst_n low, state SHALL be IDLE, accumulator 0, sticky flag 0, m_status_valid 0, m_status_len 0, m_status_bad/oversize/saturated 0, frame_count 0, bad_frame_count 0; s_axis_tready therefore 1.
REQ-022 Reset mid-frame SHALL discard the partial frame; no record is emitted for it.

Structure
REQ-023 No shared package; all widths are local parameters derived from module parameters.
REQ-024 Popcount SHALL be a combinational function within the module; no sub-module.

Verification
REQ-025 KEEP_WIDTH=8, frame 3 beats keep FF,FF,0F tuser 0 -> one record len=20, bad=0, oversize=0, frame_count=1.
REQ-026 Single-beat frame keep 01 tuser 1 -> len=1, bad=1, bad_frame_count=1, state never leaves IDLE.
REQ-027 m_status_ready=0 after first record, second frame offered -> tready=0 until ready=1; second record len correct, no beat lost.
REQ-028 LEN_WIDTH=8, 40 full beats keep FF -> len=255, saturated=1, oversize=0 with MAX_LEN=1518 (255 ≤ MAX_LEN).
REQ-029 Back-to-back single-beat frames with m_status_ready=1 -> one record per cycle, tready constantly 1, frame_count increments every cycle.
REQ-030 rst_n asserted after 2 beats of a frame -> all outputs at reset values, no record emitted; next frame counts from 0.
